// File: rtl/fizzbuzz_stream.sv
// fizzbuzz_stream: walks an inclusive number range and streams each number with
// divisibility flags, using residue counters seeded by a bit-serial remainder pass.

module fizzbuzz_residue #(
    parameter int unsigned DIV = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic shift_i,
    input  logic bit_i,
    input  logic step_i,
    output logic zero_o
);
    localparam int RW = $clog2(DIV);
    localparam logic [RW:0]   DIVX = (RW+1)'(DIV);
    localparam logic [RW-1:0] DMAX = RW'(DIV - 1);

    logic [RW-1:0] rem_q, rem_d;
    logic [RW:0]   wide;

    always_comb begin
        rem_d = rem_q;
        wide  = {rem_q, bit_i};
        if (clr_i)
            rem_d = '0;
        else if (shift_i)
            rem_d = (wide >= DIVX) ? RW'(wide - DIVX) : wide[RW-1:0];
        else if (step_i)
            rem_d = (rem_q == DMAX) ? '0 : rem_q + RW'(1);
    end

    // Flag of the value the residue holds after this edge.
    assign zero_o = (rem_d == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rem_q <= '0;
        else     rem_q <= rem_d;
    end
endmodule

module fizzbuzz_stream #(
    parameter int          WIDTH = 8,
    parameter int unsigned DIV_A = 3,
    parameter int unsigned DIV_B = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] first,
    input  logic [WIDTH-1:0] last,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_number,
    output logic             out_fizz,
    output logic             out_buzz,
    output logic             out_last,
    output logic             done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] last_q, last_d, num_q, num_d;
    logic             fizz_q, fizz_d, buzz_q, buzz_d, lastf_q, lastf_d, done_q, done_d;
    logic             clr, shift, step, zero_a, zero_b;

    fizzbuzz_residue #(.DIV(DIV_A)) u_res_a (
        .clk(clk), .rst(rst), .clr_i(clr), .shift_i(shift), .bit_i(num_q[WIDTH-1]),
        .step_i(step), .zero_o(zero_a)
    );
    fizzbuzz_residue #(.DIV(DIV_B)) u_res_b (
        .clk(clk), .rst(rst), .clr_i(clr), .shift_i(shift), .bit_i(num_q[WIDTH-1]),
        .step_i(step), .zero_o(zero_b)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        num_d   = num_q;
        fizz_d  = fizz_q;
        buzz_d  = buzz_q;
        lastf_d = lastf_q;
        done_d  = 1'b0;
        clr     = 1'b0;
        shift   = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                if (first <= last) begin
                    state_d = S_INIT;
                    num_d   = first;
                    last_d  = last;
                    cnt_d   = CW'(WIDTH);
                    clr     = 1'b1;
                end else begin
                    done_d = 1'b1;
                end
            end
            S_INIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    // Rotating feeds bits MSB first and leaves first intact after WIDTH steps.
                    shift = 1'b1;
                    cnt_d = cnt_q - CW'(1);
                    num_d = {num_q[WIDTH-2:0], num_q[WIDTH-1]};
                end else begin
                    state_d = S_RUN;
                    fizz_d  = zero_a;
                    buzz_d  = zero_b;
                    lastf_d = (num_q == last_q);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    if (lastf_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        step    = 1'b1;
                        num_d   = num_q + WIDTH'(1);
                        fizz_d  = zero_a;
                        buzz_d  = zero_b;
                        lastf_d = (num_d == last_q);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            num_q   <= '0;
            fizz_q  <= 1'b0;
            buzz_q  <= 1'b0;
            lastf_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            num_q   <= num_d;
            fizz_q  <= fizz_d;
            buzz_q  <= buzz_d;
            lastf_q <= lastf_d;
            done_q  <= done_d;
        end
    end

    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_RUN);
    assign out_number = num_q;
    assign out_fizz   = fizz_q;
    assign out_buzz   = buzz_q;
    assign out_last   = lastf_q;
    assign done       = done_q;
endmodule

// File: tb/tb_fizzbuzz_stream.sv
// Bench for fizzbuzz_stream: default-parameter instance for function, timing and
// cancellation, plus a WIDTH=12 / 7 / 11 instance swept over its full range.
module tb_fizzbuzz_stream;
    localparam int W8 = 8;

    typedef struct packed {
        logic [15:0] num;
        logic        fz;
        logic        bz;
        logic        lt;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          start = 0, abort = 0, out_ready = 1;
    logic [W8-1:0] first = 0, last = 0;
    logic          busy, out_valid, out_fizz, out_buzz, out_last, done;
    logic [W8-1:0] out_number;

    logic        start2 = 0, abort2 = 0, ready2 = 1;
    logic [11:0] first2 = 0, last2 = 0;
    logic        busy2, valid2, fizz2, buzz2, lastf2, done2;
    logic [11:0] num2;

    fizzbuzz_stream u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .first(first), .last(last),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_number(out_number),
        .out_fizz(out_fizz), .out_buzz(out_buzz), .out_last(out_last), .done(done)
    );

    fizzbuzz_stream #(.WIDTH(12), .DIV_A(7), .DIV_B(11)) u_dut12 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2), .first(first2), .last(last2),
        .busy(busy2), .out_valid(valid2), .out_ready(ready2), .out_number(num2),
        .out_fizz(fizz2), .out_buzz(buzz2), .out_last(lastf2), .done(done2)
    );

    int checks = 0, errors = 0, done_cnt = 0;
    bit rmode = 0;
    beat_t q8[$], q12[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 out_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic        stall8 = 0;
    logic [10:0] held8 = 0;
    always @(negedge clk) begin
        beat_t e;
        if (!rst) begin
            if (done) done_cnt++;
            if (out_valid) begin
                if (stall8) chk("hold", {out_number, out_fizz, out_buzz, out_last}, held8);
                if (out_ready && !abort) begin
                    if (q8.size() == 0) chk("extra_beat", q8.size(), 1);
                    else begin
                        e = q8.pop_front();
                        chk("num", out_number, e.num);
                        chk("flags", {out_fizz, out_buzz, out_last}, {e.fz, e.bz, e.lt});
                    end
                end
                stall8 = !out_ready;
                held8  = {out_number, out_fizz, out_buzz, out_last};
            end else begin
                stall8 = 0;
            end
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (!rst && valid2 && ready2) begin
            if (q12.size() == 0) chk("extra_beat12", q12.size(), 1);
            else begin
                e = q12.pop_front();
                chk("beat12", {num2, fizz2, buzz2, lastf2}, {e.num[11:0], e.fz, e.bz, e.lt});
            end
        end
    end

    task automatic run8(input int f, input int l, input bit timed);
        int k, fv, n;
        n = (f <= l) ? l - f + 1 : 0;
        for (int v = f; v <= l; v++)
            q8.push_back('{num: 16'(v), fz: (v % 3 == 0), bz: (v % 5 == 0), lt: (v == l)});
        first = W8'(f); last = W8'(l); start = 1;
        @(posedge clk); #1 start = 0;
        chk("busy_at_start", busy, n != 0);
        k = 0; fv = -1;
        while (!done && k < 3000) begin
            @(posedge clk); #1; k++;
            if (out_valid && fv < 0) fv = k;
        end
        chk("done_seen", done, 1);
        if (timed) begin
            chk("first_valid", fv, (n != 0) ? W8 + 1 : -1);
            chk("run_len", k, (n != 0) ? W8 + 1 + n : 0);
        end
        @(posedge clk); #1;
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);
        chk("queue_drained", q8.size(), 0);
        q8.delete();
    endtask

    initial begin
        int k, dc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_number", out_number, 0);
        chk("rst_flags", {out_fizz, out_buzz, out_last}, 0);
        chk("rst_done", done, 0);
        chk("rst_dut12", {busy2, valid2, num2, fizz2, buzz2, lastf2, done2}, 0);
        rst = 0;
        @(posedge clk); #1;

        run8(0, 15, 1);
        run8(250, 255, 1);
        chk("no_wrap", out_number, 255);
        rmode = 1;
        run8(0, 100, 0);
        rmode = 0;
        @(posedge clk); #1;
        run8(10, 9, 1);

        for (int v = 0; v < 40; v++)
            q8.push_back('{num: 16'(v), fz: (v % 3 == 0), bz: (v % 5 == 0), lt: 1'b0});
        first = 0; last = 99; start = 1;
        @(posedge clk); #1 start = 0;
        k = 0;
        while (!(out_valid && out_number == 40) && k < 500) begin
            @(posedge clk); #1; k++;
        end
        chk("reached_40", out_number, 40);
        dc = done_cnt;
        abort = 1;
        @(posedge clk); #1 abort = 0;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, dc);
        chk("abort_queue", q8.size(), 0);
        q8.delete();

        first = 0; last = 7; start = 1;
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("init_busy", busy, 1);
        rst = 1;
        #1;
        chk("rst_async", {busy, out_valid, out_number, out_fizz, out_buzz, out_last, done}, 0);
        @(posedge clk); #1 rst = 0;
        @(posedge clk); #1;
        run8(5, 7, 1);

        for (int v = 0; v < 4096; v++)
            q12.push_back('{num: 16'(v), fz: (v % 7 == 0), bz: (v % 11 == 0), lt: (v == 4095)});
        first2 = 0; last2 = 12'd4095; start2 = 1;
        @(posedge clk); #1 start2 = 0;
        repeat (40) @(posedge clk);
        #1;
        chk("run12_valid", valid2, 1);
        first2 = 100; last2 = 200; start2 = 1;
        @(posedge clk); #1 start2 = 0;
        k = 0;
        while (!done2 && k < 6000) begin
            @(posedge clk); #1; k++;
        end
        chk("done12_seen", done2, 1);
        repeat (5) @(posedge clk);
        #1;
        chk("start_ignored", {busy2, valid2}, 0);
        chk("queue12_drained", q12.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/fizzbuzz_stream.md
# fizzbuzz_stream

Sequential, parametrised successor to the combinational fizz/buzz classifier. On a start command it walks an inclusive range of numbers and streams one beat per number over a valid/ready handshake. Each beat carries the number and two divisibility flags for configurable divisors. Divisibility comes from running residue counters seeded by a bit-serial remainder pass, so no multiplier sits in the datapath. The block sits between a control register block (`first`/`last`/`start`) and a downstream consumer.

## Interface
- `WIDTH`, 8: number width in bits; 2..32.
- `DIV_A`, 3: divisor for `fizz`; 2..2^WIDTH-1.
- `DIV_B`, 5: divisor for `buzz`; 2..2^WIDTH-1.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a run; honoured in IDLE only.
- `abort`  in  1  cancel a run in progress.
- `first`  in  WIDTH  first number of range, sampled with `start`.
- `last`  in  WIDTH  last number of range (inclusive), sampled with `start`.
- `busy`  out  1  high in INIT and RUN.
- `out_valid`  out  1  beat available.
- `out_ready`  in  1  consumer accepts beat.
- `out_number`  out  WIDTH  current number.
- `out_fizz`  out  1  `out_number % DIV_A == 0`.
- `out_buzz`  out  1  `out_number % DIV_B == 0`.
- `out_last`  out  1  `out_number == last`.
- `done`  out  1  one-cycle pulse after the final beat is accepted.

## Operation
- States: IDLE, INIT, RUN.
- **IDLE**
  - `start` high with `first <= last`: latch `first` and `last`, clear both remainders, set bit index to WIDTH-1, go to INIT.
  - `start` high with `first > last`: stay in IDLE, pulse `done` next cycle, produce no beats.
- **INIT** (exactly WIDTH cycles)
  - Restoring remainder, MSB first, run for both divisors in parallel.
  - Per cycle: `r = (r<<1) | first[idx]`; if `r >= DIV`, `r = r - DIV`.
  - Intermediate width is clog2(DIV)+1; stored remainder width is clog2(DIV).
  - After bit 0 is processed, load `out_number = first`, go to RUN.
- **RUN**
  - `out_valid = 1`.
  - `out_fizz = (rem_a == 0)`, `out_buzz = (rem_b == 0)`, `out_last = (out_number == last)`, all registered.
  - Handshake (`out_valid & out_ready`), not last: `out_number += 1`; `rem_a = (rem_a == DIV_A-1) ? 0 : rem_a+1`; same rule for `rem_b`.
  - Handshake on last: go to IDLE, pulse `done`.
  - `out_number` never wraps; `last = 2^WIDTH-1` ends the run without incrementing.
- While `out_valid & !out_ready`, all `out_*` hold stable.
- `out_valid` drops without a handshake only on `abort` or `rst`.
- `abort` in INIT or RUN: go to IDLE next edge, `out_valid` and `busy` go low, no `done` pulse. `abort` in IDLE has no effect.
- `abort` has priority over a same-cycle handshake; that beat counts as not accepted.
- `start` outside IDLE is ignored, including `start` in the same cycle as `done`.
- `start` and `abort` asserted together in IDLE: `start` wins.

## Timing
- Reset values: state IDLE; `busy`, `out_valid`, `out_fizz`, `out_buzz`, `out_last`, `done` = 0; `out_number` = 0; remainders 0.
- `rst` mid-run takes effect immediately (asynchronous) and returns all outputs to their reset values.
- `start` sampled at edge E: `busy` = 1 from E. First `out_valid` is high after edge E+WIDTH+1.
- Throughput: 1 beat/cycle with `out_ready` held high.
- With `out_ready` held high, the run ends WIDTH+1+(last-first+1) cycles after E.
- Final handshake at edge F: `done` = 1 and `busy` = 0 for the cycle after F only.
- `out_valid` may rise with `out_ready` low. The block never waits for `out_ready` before asserting valid.

## Test plan
- **Basic range:** WIDTH=8, `first`=0, `last`=15, `out_ready`=1 → 16 beats 0..15. `fizz` at 0,3,6,9,12,15; `buzz` at 0,5,10,15; `out_last` only on 15; `done` one cycle later; first valid 9 cycles after `start`.
- **Top of range:** `first`=250, `last`=255 → INIT residues give `buzz` on 250 and 255, `fizz` on 252 and 255. Run stops after 255 with no wrap to 0.
- **Backpressure:** random `out_ready` (~50%) over 0..100 → each number appears exactly once, in order; outputs stable while stalled; flags match `%3` / `%5`.
- **Empty range:** `first`=10, `last`=9 → no `out_valid`, `busy` stays 0, `done` pulses exactly once, the cycle after `start`.
- **Cancellation:**
  - `abort` mid-RUN at number 40 of 0..99 → no further beats, no `done`.
  - `rst` asserted mid-INIT → all outputs at reset values immediately.
  - A following `start` with 5..7 → beats 5, 6, 7 with correct flags.
- **Parameter sweep:** WIDTH=12, DIV_A=7, DIV_B=11, range 0..4095 → every beat's flags equal a modulo model. Also `start` during RUN is ignored.
